// File: rtl/apb_reg_pkg.sv
// Shared types for the APB4 to REG_BUS cut bridge.
// Bridge FSM states and the address alignment helper.
package apb_reg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  // Number of byte-offset address LSBs for a data word of dw bits.
  function automatic int unsigned align_lsbs(int unsigned dw);
    return (dw / 8 > 1) ? $clog2(dw / 8) : 0;
  endfunction

endpackage

// File: rtl/apb4_to_reg_cut.sv
// APB4 completer to REG_BUS request/response bridge, registered both ways.
// Ports: clk_i/rst_ni; APB psel/penable/pwrite/paddr/pwdata/pstrb in,
// prdata/pready/pslverr out; REG addr/write/wdata/wstrb/valid out,
// rdata/ready/error in. Optional bus-hang timeout and misalign error.
import apb_reg_pkg::*;

module apb4_to_reg_cut #(
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = 0,
  parameter bit          CheckAlign    = 1'b1,
  localparam int unsigned StrbWidth    = DataWidth / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 psel_i,
  input  logic                 penable_i,
  input  logic                 pwrite_i,
  input  logic [AddrWidth-1:0] paddr_i,
  input  logic [DataWidth-1:0] pwdata_i,
  input  logic [StrbWidth-1:0] pstrb_i,
  output logic [DataWidth-1:0] prdata_o,
  output logic                 pready_o,
  output logic                 pslverr_o,
  output logic [AddrWidth-1:0] reg_addr_o,
  output logic                 reg_write_o,
  output logic [DataWidth-1:0] reg_wdata_o,
  output logic [StrbWidth-1:0] reg_wstrb_o,
  output logic                 reg_valid_o,
  input  logic [DataWidth-1:0] reg_rdata_i,
  input  logic                 reg_ready_i,
  input  logic                 reg_error_i
);

  localparam int unsigned AlignLsbs = align_lsbs(DataWidth);

  state_e state_q, state_d;

  logic [AddrWidth-1:0] addr_q;
  logic                 write_q;
  logic [DataWidth-1:0] wdata_q;
  logic [StrbWidth-1:0] wstrb_q;
  logic [DataWidth-1:0] rdata_q;
  logic                 err_q;

  logic access;
  logic misalign;
  logic timeout;

  // Setup phase (psel without penable) never launches a request.
  assign access = psel_i & penable_i;

  if (CheckAlign && AlignLsbs > 0) begin : g_align
    assign misalign = |paddr_i[AlignLsbs-1:0];
  end else begin : g_no_align
    assign misalign = 1'b0;
  end

  if (TimeoutCycles != 0) begin : g_to
    localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
    logic [CntW-1:0] cnt_q;

    // Held at zero outside REQ, so every REQ entry starts from zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q <= '0;
      end else if (state_q != REQ) begin
        cnt_q <= '0;
      end else if (!reg_ready_i &&
                   cnt_q != CntW'(TimeoutCycles)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    // Ready in the expiry cycle takes priority.
    assign timeout = !reg_ready_i &&
                     (cnt_q == CntW'(TimeoutCycles - 1));
  end else begin : g_no_to
    assign timeout = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (access) state_d = misalign ? RESP : REQ;
      end
      REQ: begin
        if (reg_ready_i || timeout) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (state_q == IDLE && access) begin
      addr_q  <= paddr_i;
      write_q <= pwrite_i;
      wdata_q <= pwdata_i;
      wstrb_q <= pwrite_i ? pstrb_i : '0;
      rdata_q <= '0;
      err_q   <= misalign;
    end else if (state_q == REQ) begin
      if (reg_ready_i) begin
        rdata_q <= write_q ? '0 : reg_rdata_i;
        err_q   <= reg_error_i;
      end else if (timeout) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end
  end

  assign reg_valid_o = (state_q == REQ);
  assign reg_addr_o  = addr_q;
  assign reg_write_o = write_q;
  assign reg_wdata_o = wdata_q;
  assign reg_wstrb_o = wstrb_q;

  assign pready_o  = (state_q == RESP);
  assign prdata_o  = pready_o ? rdata_q : '0;
  assign pslverr_o = pready_o & err_q;

endmodule

// File: tb/tb_apb4_to_reg_cut.sv
// Self-checking bench for apb4_to_reg_cut.
// Directed APB transfers against a transaction-level timing model.
module tb_apb4_to_reg_cut;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        psel_i = 1'b0;
  logic        penable_i = 1'b0;
  logic        pwrite_i = 1'b0;
  logic [31:0] paddr_i = '0;
  logic [31:0] pwdata_i = '0;
  logic [3:0]  pstrb_i = '0;
  logic [31:0] prdata_o;
  logic        pready_o;
  logic        pslverr_o;
  logic [31:0] reg_addr_o;
  logic        reg_write_o;
  logic [31:0] reg_wdata_o;
  logic [3:0]  reg_wstrb_o;
  logic        reg_valid_o;
  logic [31:0] reg_rdata_i = '0;
  logic        reg_ready_i = 1'b0;
  logic        reg_error_i = 1'b0;

  apb4_to_reg_cut #(
    .AddrWidth    (32),
    .DataWidth    (32),
    .TimeoutCycles(TO),
    .CheckAlign   (1'b1)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .psel_i     (psel_i),
    .penable_i  (penable_i),
    .pwrite_i   (pwrite_i),
    .paddr_i    (paddr_i),
    .pwdata_i   (pwdata_i),
    .pstrb_i    (pstrb_i),
    .prdata_o   (prdata_o),
    .pready_o   (pready_o),
    .pslverr_o  (pslverr_o),
    .reg_addr_o (reg_addr_o),
    .reg_write_o(reg_write_o),
    .reg_wdata_o(reg_wdata_o),
    .reg_wstrb_o(reg_wstrb_o),
    .reg_valid_o(reg_valid_o),
    .reg_rdata_i(reg_rdata_i),
    .reg_ready_i(reg_ready_i),
    .reg_error_i(reg_error_i)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at cyc %0d",
               nm, act, exp, cyc);
    end
  endtask

  // Model state describing the transfer in flight.
  bit          active = 1'b0;
  int          t1 = 0;
  int          m_nv = 0;
  logic [31:0] m_rdata = '0;
  bit          m_err = 1'b0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  bit          m_write = 1'b0;
  logic [3:0]  m_wstrb = '0;

  // Number of cycles the REG request stays valid.
  function automatic int model_nv(bit mis, bit hr, int d);
    if (mis) return 0;
    if (hr && d < TO) return d + 1;
    return TO;
  endfunction

  always @(negedge clk) begin
    bit ev;
    bit erd;
    ev  = active && (cyc >= t1) && (cyc < t1 + m_nv);
    erd = active && (cyc == t1 + m_nv);
    chk("reg_valid", reg_valid_o, ev);
    chk("pready", pready_o, erd);
    chk("prdata", prdata_o, erd ? m_rdata : 32'h0);
    chk("pslverr", pslverr_o, erd ? m_err : 1'b0);
    if (ev && reg_valid_o) begin
      chk("reg_addr", reg_addr_o, m_addr);
      chk("reg_wdata", reg_wdata_o, m_wdata);
      chk("reg_ctl", {reg_write_o, reg_wstrb_o},
          {m_write, m_wstrb});
    end
  end

  task automatic xfer(bit wr, logic [31:0] a,
                      logic [31:0] wd, logic [3:0] st,
                      bit hr, int d, logic [31:0] rd, bit er,
                      int lit_lat, logic [31:0] lit_rd,
                      bit lit_err, int lit_nv);
    bit          mis;
    bit          tmo;
    bit          done;
    bit          rdy;
    int          nvalid;
    int          lat;
    logic [31:0] got_rd;
    bit          got_err;
    mis = (a[1:0] != 2'b00);
    tmo = !mis && !(hr && d < TO);
    @(posedge clk); #1;
    psel_i = 1'b1; penable_i = 1'b0;
    pwrite_i = wr; paddr_i = a;
    pwdata_i = wd; pstrb_i = st;
    @(posedge clk); #1;
    penable_i = 1'b1;
    t1 = cyc + 1;
    m_nv = model_nv(mis, hr, d);
    m_rdata = (mis || tmo || wr) ? 32'h0 : rd;
    m_err = (mis || tmo) ? 1'b1 : er;
    m_addr = a; m_wdata = wd; m_write = wr;
    m_wstrb = wr ? st : 4'h0;
    active = 1'b1;
    done = 1'b0; nvalid = 0; lat = -1;
    got_rd = '0; got_err = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk); #1;
      rdy = hr && !mis && (cyc == t1 + d);
      reg_ready_i = rdy;
      reg_rdata_i = rdy ? rd : 32'hBADC0DE5;
      reg_error_i = rdy ? er : 1'b1;
      @(negedge clk);
      if (reg_valid_o) nvalid++;
      if (pready_o) begin
        done = 1'b1;
        lat = cyc - t1;
        got_rd = prdata_o;
        got_err = pslverr_o;
      end
    end
    chk("pready_seen", done, 1'b1);
    chk("latency", lat, lit_lat);
    chk("lit_prdata", got_rd, lit_rd);
    chk("lit_pslverr", got_err, lit_err);
    chk("lit_nvalid", nvalid, lit_nv);
    @(posedge clk); #1;
    psel_i = 1'b0; penable_i = 1'b0;
    reg_ready_i = 1'b0; reg_error_i = 1'b0;
    active = 1'b0;
  endtask

  task automatic reset_in_req();
    @(posedge clk); #1;
    psel_i = 1'b1; penable_i = 1'b0;
    pwrite_i = 1'b0; paddr_i = 32'h30;
    pwdata_i = 32'h0; pstrb_i = 4'h0;
    @(posedge clk); #1;
    penable_i = 1'b1;
    t1 = cyc + 1;
    m_nv = TO; m_rdata = '0; m_err = 1'b1;
    m_addr = 32'h30; m_wdata = '0;
    m_write = 1'b0; m_wstrb = '0;
    active = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("valid_before_rst", reg_valid_o, 1'b1);
    rst_ni = 1'b0;
    active = 1'b0;
    #1;
    chk("rst_valid", reg_valid_o, 1'b0);
    chk("rst_pready", pready_o, 1'b0);
    chk("rst_outs", {prdata_o, pslverr_o, reg_wstrb_o},
        37'h0);
    chk("rst_addr", reg_addr_o, 32'h0);
    psel_i = 1'b0; penable_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
  endtask

  initial begin
    #3;
    chk("init_valid", reg_valid_o, 1'b0);
    chk("init_resp", {pready_o, pslverr_o, prdata_o}, 34'h0);
    chk("init_req", {reg_addr_o, reg_wdata_o}, 64'h0);
    chk("init_ctl", {reg_write_o, reg_wstrb_o}, 5'h0);
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;

    // Write, immediate ready: pready at T2.
    xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'b0011,
         1'b1, 0, 32'h0, 1'b0,
         1, 32'h0, 1'b0, 1);
    // Read, ready after 5 wait cycles.
    xfer(1'b0, 32'h20, 32'h0, 4'b1111,
         1'b1, 5, 32'h12345678, 1'b0,
         6, 32'h12345678, 1'b0, 6);
    // Read with no ready: timeout.
    xfer(1'b0, 32'h24, 32'h0, 4'h0,
         1'b0, 0, 32'h0, 1'b0,
         8, 32'h0, 1'b1, 8);
    // Misaligned write.
    xfer(1'b1, 32'h13, 32'hAAAA5555, 4'hF,
         1'b1, 0, 32'h0, 1'b0,
         0, 32'h0, 1'b1, 0);
    // Misaligned read.
    xfer(1'b0, 32'h22, 32'h0, 4'h0,
         1'b1, 0, 32'h77, 1'b0,
         0, 32'h0, 1'b1, 0);
    // Read with slave error.
    xfer(1'b0, 32'h40, 32'h0, 4'h0,
         1'b1, 2, 32'hCAFEF00D, 1'b1,
         3, 32'hCAFEF00D, 1'b1, 3);
    // Ready in the timeout expiry cycle wins.
    xfer(1'b0, 32'h48, 32'h0, 4'h0,
         1'b1, 7, 32'h0BADF00D, 1'b0,
         8, 32'h0BADF00D, 1'b0, 8);
    xfer(1'b0, 32'h4C, 32'h0, 4'h0,
         1'b1, 7, 32'h01020304, 1'b1,
         8, 32'h01020304, 1'b1, 8);
    // Write timeout.
    xfer(1'b1, 32'h50, 32'h11223344, 4'b1000,
         1'b0, 0, 32'h0, 1'b0,
         8, 32'h0, 1'b1, 8);
    // Reset mid-request, then a normal write.
    reset_in_req();
    xfer(1'b1, 32'h44, 32'h00000005, 4'hF,
         1'b1, 1, 32'h0, 1'b0,
         2, 32'h0, 1'b0, 2);
    xfer(1'b0, 32'hFC, 32'h0, 4'h0,
         1'b1, 0, 32'h89ABCDEF, 1'b0,
         1, 32'h89ABCDEF, 1'b0, 1);

    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
